mark_counter_seq: RTL and testbench
===================================

# mark_counter_seq

Sequential, parametrised mark counter for the Golomb ruler search, usable at any rank of the ruler, including the last mark. When started, it advances its mark to the next candidate position. It then checks the new distances against the already-used distance set, one earlier mark per clock. A candidate that clashes is skipped internally, without involving the controller. Each start ends in exactly one of three results: leaf success, hand-off to the next mark (distances extended), or exhaustion (hand back to the previous mark).

## Interface
Parameters:
- LEVEL, 1: rank of this mark on the ruler, 1..NUMMARKS.
- NUMMARKS, 6: maximum number of marks carried in `marks_in`.
- W, 9: position width.
- LVLW, 7: width of level/enable fields.
- MAXVALUE, 500: size of the distance bit set. Requires `limit` ≤ MAXVALUE.
- LEAF, 1: 1 = last mark (reports success); 0 = inner mark (hands off to LEVEL+1).

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- load  in  1  in IDLE: `val` <= `resetvalue`; ignored when busy.
- resetvalue  in  W  value loaded by `load`.
- start  in  1  one-cycle request; accepted only in IDLE with `enabled`==LEVEL.
- abort  in  1  cancel any operation in progress.
- enabled  in  LVLW  currently active mark rank.
- startvalue  in  W  first candidate used when `val`==0.
- limit  in  W  inclusive upper bound for `val`.
- distances  in  MAXVALUE  bit d-1 set = distance d already used.
- marks_in  in  NUMMARKS*W  mark k occupies bits [k*W-1:(k-1)*W].
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle result strobe.
- val  out  W  current mark position.
- next_enabled  out  LVLW  rank that is enabled next; valid with `done`, then held.
- success  out  1  leaf found a valid ruler; valid with `done`, then held.
- distances_out  out  MAXVALUE  `distances` OR this mark's new distances; valid with `done` when handing off.

## Operation
- Reset values: state IDLE, `val`=0, `busy`=0, `done`=0, `success`=0, `next_enabled`=LEVEL, `distances_out`=0. The pair-distance set `pd` and the index `i` are cleared.
- States: IDLE, STEP, CHECK, FINISH.
- IDLE: `start`&&`enabled`==LEVEL → STEP. `success` is cleared on acceptance. `start` under any other condition is ignored.
- STEP: the candidate is `startvalue` if `val`==0, else `val`+1 computed at W+1 bits.
  - If the carry is set or candidate > `limit`: `val`<=0, `next_enabled`<=LEVEL-1, `success`<=0, → FINISH.
  - Otherwise: `val`<=candidate, `pd`<=0, `i`<=1, → CHECK. With LEVEL==1 there are no marks to check, so the candidate is treated as good immediately.
- CHECK, one mark per cycle: d = `val` − m[i], computed at W bits.
  - Clash if d==0, d>MAXVALUE, `distances`[d-1], or `pd`[d-1]. On a clash → STEP, which tries the next candidate.
  - Otherwise `pd`[d-1]<=1 and `i`++. When `i` reaches LEVEL the candidate is good.
- Good, LEAF=1: `success`<=1, `next_enabled`<=LEVEL. The next `start` resumes from `val`+1.
- Good, LEAF=0: `success`<=0, `next_enabled`<=LEVEL+1, `distances_out`<=`distances`|`pd`. Then → FINISH.
- FINISH: `done`=1 for this cycle only, then → IDLE.
- `abort`, in any non-IDLE state:
  - → IDLE on the next edge, with no `done`.
  - `val` keeps the last committed candidate.
  - `next_enabled` and `success` are unchanged.
- `abort` together with `start` in IDLE: `abort` wins and `start` is dropped.
- `marks_in`, `limit`, `distances` and `startvalue` must be held stable while `busy`. They are not captured.

## Timing
- One candidate costs 1 STEP cycle plus LEVEL−1 CHECK cycles, or fewer if a clash aborts the check early.
- Exhaustion: `done` is high 2 edges after `start` is sampled.
- First candidate good: `done` is high LEVEL+1 edges after `start` is sampled.
- `busy` rises on the edge that accepts `start` and falls on the edge that leaves FINISH.
- A new `start` may be accepted in the cycle after `done`.
- Asserting `reset_n` low mid-operation forces all outputs to their reset values immediately, with no `done`.

## Structure
- Shared package `golomb_pkg`:
  - W and LVLW defaults.
  - State enum {IDLE, STEP, CHECK, FINISH}.
  - A `mark_at(marks, k)` slice helper.
- Sub-module `mark_distance_probe`: combinational. It takes `val`, m[i], `distances` and `pd`, and produces d and the clash flag. It is reused by later multi-probe variants.

## Test plan
- LEAF=1, LEVEL=3, m1=0, m2=1, distances={1}, val=0, startvalue=2, limit=6, start → candidate 2 clashes (d=1), candidate 3 is accepted: val=3, success=1, next_enabled=3, done 7 edges after start.
- LEAF=1, LEVEL=3, val=3, limit=3, start → val=0, next_enabled=2, success=0, done 2 edges after start.
- LEAF=0, LEVEL=2, m1=0, distances={}, val=0, startvalue=1, limit=10 → val=1, next_enabled=3, success=0, distances_out has only bit 0 set.
- W=9, load resetvalue=511, limit=511, start → the carry forces exhaustion: val=0, next_enabled=LEVEL-1.
- abort in the second CHECK cycle → busy low 1 edge later, no done pulse. Then start with enabled≠LEVEL → ignored, busy stays 0.
- reset_n pulsed low during CHECK → val=0, busy=0, done=0, next_enabled=LEVEL, distances_out=0, asynchronously, before the next edge.

Source files
------------

// File: rtl/golomb_pkg.sv
`default_nettype none
// ============================================================================
// golomb_pkg : shared types, defaults and helpers for the Golomb mark counters
// Revision   : 1.0
// ============================================================================
package golomb_pkg;

  localparam int W_DEF      = 9;
  localparam int LVLW_DEF   = 7;
  localparam int MARKS_BITS = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Mark k (1-based) of a packed mark vector, zero-extended to 32 bits.
  function automatic logic [31:0] mark_at(input logic [MARKS_BITS-1:0] marks,
                                          input int unsigned k,
                                          input int unsigned w);
    logic [MARKS_BITS-1:0] w_sh;
    w_sh = marks >> ((k - 1) * w);
    return w_sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mark_distance_probe.sv
`default_nettype none
// ============================================================================
// mark_distance_probe : distance from one earlier mark plus clash detection
// Revision            : 1.0
// ============================================================================
module mark_distance_probe #(
  parameter int W        = 9,
  parameter int MAXVALUE = 500
) (
  input  logic [W-1:0]        i_val,
  input  logic [W-1:0]        i_mark,
  input  logic [MAXVALUE-1:0] i_distances,
  input  logic [MAXVALUE-1:0] i_pd,
  output logic [W-1:0]        o_d,
  output logic                o_clash
);

  logic                w_in_range;
  logic [MAXVALUE-1:0] w_onehot;
  logic                w_used;

  assign o_d        = i_val - i_mark;
  assign w_in_range = (o_d != '0) && (32'(o_d) <= MAXVALUE);
  // Out-of-range distances shift the one-hot away entirely; w_in_range covers them.
  assign w_onehot   = {{(MAXVALUE-1){1'b0}}, 1'b1} << (o_d - {{(W-1){1'b0}}, 1'b1});
  assign w_used     = |((i_distances | i_pd) & w_onehot);
  assign o_clash    = !w_in_range || w_used;

endmodule
`default_nettype wire

// File: rtl/mark_counter_seq.sv
`default_nettype none
// ============================================================================
// mark_counter_seq : sequential Golomb-ruler mark counter, one distance check per clock
// Revision         : 1.0
// ============================================================================
module mark_counter_seq
  import golomb_pkg::*;
#(
  parameter int LEVEL    = 1,
  parameter int NUMMARKS = 6,
  parameter int W        = W_DEF,
  parameter int LVLW     = LVLW_DEF,
  parameter int MAXVALUE = 500,
  parameter int LEAF     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [W-1:0]          resetvalue,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LVLW-1:0]       enabled,
  input  logic [W-1:0]          startvalue,
  input  logic [W-1:0]          limit,
  input  logic [MAXVALUE-1:0]   distances,
  input  logic [NUMMARKS*W-1:0] marks_in,
  output logic                  busy,
  output logic                  done,
  output logic [W-1:0]          val,
  output logic [LVLW-1:0]       next_enabled,
  output logic                  success,
  output logic [MAXVALUE-1:0]   distances_out
);

  state_t              r_state;
  logic [W-1:0]        r_val;
  logic                r_busy;
  logic                r_done;
  logic                r_success;
  logic [LVLW-1:0]     r_next_en;
  logic [MAXVALUE-1:0] r_dist_out;
  logic [MAXVALUE-1:0] r_pd;
  logic [LVLW-1:0]     r_i;

  logic [W:0]          w_cand;
  logic                w_exhaust;
  logic [W-1:0]        w_mark;
  logic [W-1:0]        w_d;
  logic                w_clash;
  logic [MAXVALUE-1:0] w_bit;
  logic [MAXVALUE-1:0] w_good_dist;
  logic                w_last;
  logic                w_good;

  // Extra bit so that stepping past 2**W-1 shows up as a carry, not a wrap to 0.
  assign w_cand    = (r_val == '0) ? {1'b0, startvalue}
                                   : {1'b0, r_val} + {{W{1'b0}}, 1'b1};
  assign w_exhaust = w_cand[W] || (w_cand[W-1:0] > limit);
  assign w_mark    = W'(mark_at(MARKS_BITS'(marks_in), 32'(r_i), W));

  mark_distance_probe #(
    .W        (W),
    .MAXVALUE (MAXVALUE)
  ) u_probe (
    .i_val       (r_val),
    .i_mark      (w_mark),
    .i_distances (distances),
    .i_pd        (r_pd),
    .o_d         (w_d),
    .o_clash     (w_clash)
  );

  assign w_bit       = {{(MAXVALUE-1){1'b0}}, 1'b1} << (w_d - {{(W-1){1'b0}}, 1'b1});
  assign w_last      = (r_i == LVLW'(LEVEL - 1));
  assign w_good      = !abort &&
                       (((r_state == STEP)  && !w_exhaust && (LEVEL == 1)) ||
                        ((r_state == CHECK) && !w_clash   && w_last));
  assign w_good_dist = (r_state == STEP) ? distances : (distances | r_pd | w_bit);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_val      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
      r_next_en  <= LVLW'(LEVEL);
      r_dist_out <= '0;
      r_pd       <= '0;
      r_i        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) r_val <= resetvalue;
          if (start && !abort && (enabled == LVLW'(LEVEL))) begin
            r_state   <= STEP;
            r_busy    <= 1'b1;
            r_success <= 1'b0;
          end
        end
        STEP: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_exhaust) begin
            r_val     <= '0;
            r_next_en <= LVLW'(LEVEL - 1);
            r_success <= 1'b0;
            r_state   <= FINISH;
            r_done    <= 1'b1;
          end else begin
            r_val   <= w_cand[W-1:0];
            r_pd    <= '0;
            r_i     <= LVLW'(1);
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_clash) begin
            r_state <= STEP;
          end else begin
            r_pd <= r_pd | w_bit;
            r_i  <= r_i + LVLW'(1);
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A good candidate overrides the per-state next-state choice above.
      if (w_good) begin
        r_state <= FINISH;
        r_done  <= 1'b1;
        if (LEAF != 0) begin
          r_success <= 1'b1;
          r_next_en <= LVLW'(LEVEL);
        end else begin
          r_success  <= 1'b0;
          r_next_en  <= LVLW'(LEVEL + 1);
          r_dist_out <= w_good_dist;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign val           = r_val;
  assign next_enabled  = r_next_en;
  assign success       = r_success;
  assign distances_out = r_dist_out;

endmodule
`default_nettype wire

// File: tb/tb_mark_counter_seq.sv
`default_nettype none
// ============================================================================
// tb_mark_counter_seq : two mark counters (leaf rank 3, inner rank 2) against a behavioural model
// Revision            : 1.0
// ============================================================================
module tb_mark_counter_seq;

  localparam int W    = 9;
  localparam int LVLW = 7;
  localparam int MAXV = 500;
  localparam int NM   = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [W-1:0]     resetvalue = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LVLW-1:0]  enabled = '0;
  logic [W-1:0]     startvalue = '0;
  logic [W-1:0]     limit = '0;
  logic [MAXV-1:0]  distances = '0;
  logic [NM*W-1:0]  marks_in = '0;

  logic [1:0]            busy_w;
  logic [1:0]            done_w;
  logic [1:0][W-1:0]     val_w;
  logic [1:0][LVLW-1:0]  ne_w;
  logic [1:0]            succ_w;
  logic [1:0][MAXV-1:0]  dist_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mark_counter_seq #(.LEVEL(3), .NUMMARKS(NM), .W(W), .LVLW(LVLW), .MAXVALUE(MAXV), .LEAF(1)) u_leaf (
    .clock(clk), .reset_n(rst_n), .load(load), .resetvalue(resetvalue), .start(start),
    .abort(abort), .enabled(enabled), .startvalue(startvalue), .limit(limit),
    .distances(distances), .marks_in(marks_in), .busy(busy_w[0]), .done(done_w[0]),
    .val(val_w[0]), .next_enabled(ne_w[0]), .success(succ_w[0]), .distances_out(dist_w[0]));

  mark_counter_seq #(.LEVEL(2), .NUMMARKS(NM), .W(W), .LVLW(LVLW), .MAXVALUE(MAXV), .LEAF(0)) u_inner (
    .clock(clk), .reset_n(rst_n), .load(load), .resetvalue(resetvalue), .start(start),
    .abort(abort), .enabled(enabled), .startvalue(startvalue), .limit(limit),
    .distances(distances), .marks_in(marks_in), .busy(busy_w[1]), .done(done_w[1]),
    .val(val_w[1]), .next_enabled(ne_w[1]), .success(succ_w[1]), .distances_out(dist_w[1]));

  task automatic check(input string nm, input int k, input logic [MAXV-1:0] act, input logic [MAXV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic bit leaf_of(input int k);
    return (k == 0);
  endfunction

  // Walks the candidate sequence by the search rules and counts the clock edges it costs.
  task automatic model_run(input int lvl, input bit leaf, input int v0,
                           input logic [MAXV-1:0] dprev,
                           output int vres, output bit succ, output int ne,
                           output logic [MAXV-1:0] dout, output int ncyc);
    int  c, cand, d;
    bit  ok;
    bit  used [MAXV+1];
    c = v0; ncyc = 1; dout = dprev; succ = 0; vres = 0; ne = -1;
    for (int guard = 0; guard < 4096; guard++) begin
      cand = (c == 0) ? int'(startvalue) : c + 1;
      ncyc++;
      if (cand > (1 << W) - 1 || cand > int'(limit)) begin
        vres = 0; ne = lvl - 1; succ = 0;
        return;
      end
      c  = cand;
      ok = 1;
      for (int j = 0; j <= MAXV; j++) used[j] = 0;
      for (int j = 1; j < lvl && ok; j++) begin
        d = (cand - int'(marks_in[(j-1)*W +: W])) & ((1 << W) - 1);
        ncyc++;
        if (d == 0 || d > MAXV) ok = 0;
        else if (distances[d-1] || used[d]) ok = 0;
        else used[d] = 1;
      end
      if (ok) begin
        vres = cand;
        if (leaf) begin
          succ = 1; ne = lvl;
        end else begin
          succ = 0; ne = lvl + 1;
          dout = distances;
          for (int j = 1; j <= MAXV; j++) if (used[j]) dout[j-1] = 1'b1;
        end
        return;
      end
    end
    ncyc = -1;
  endtask

  bit              m_busy [2];
  bit              m_done [2];
  bit              m_vknown [2];
  bit              m_succ [2];
  int              m_val [2];
  int              m_ne [2];
  int              m_t [2];
  int              m_n [2];
  logic [MAXV-1:0] m_dist [2];
  int              p_val [2];
  bit              p_succ [2];
  int              p_ne [2];
  logic [MAXV-1:0] p_dist [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_done[k] = 0; m_vknown[k] = 1; m_succ[k] = 0;
        m_val[k] = 0; m_ne[k] = lvl_of(k); m_dist[k] = '0; m_t[k] = 0; m_n[k] = 0;
      end else if (m_busy[k]) begin
        if (abort) begin
          m_busy[k] = 0; m_done[k] = 0; m_vknown[k] = 0;
        end else if (m_done[k]) begin
          m_busy[k] = 0; m_done[k] = 0;
        end else begin
          m_t[k]++;
          if (m_t[k] == m_n[k]) begin
            m_done[k] = 1;
            m_val[k] = p_val[k]; m_succ[k] = p_succ[k]; m_ne[k] = p_ne[k]; m_dist[k] = p_dist[k];
          end
        end
      end else begin
        if (load) begin
          m_val[k] = int'(resetvalue); m_vknown[k] = 1;
        end
        if (start && !abort && int'(enabled) == lvl_of(k)) begin
          int vr, nr, cy; bit sr; logic [MAXV-1:0] dr;
          model_run(lvl_of(k), leaf_of(k), m_val[k], m_dist[k], vr, sr, nr, dr, cy);
          p_val[k] = vr; p_succ[k] = sr; p_ne[k] = nr; p_dist[k] = dr;
          m_n[k] = cy; m_t[k] = 1; m_busy[k] = 1; m_succ[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check("busy", k, busy_w[k], m_busy[k]);
      check("done", k, done_w[k], m_done[k]);
      check("success", k, succ_w[k], m_succ[k]);
      check("next_enabled", k, ne_w[k], m_ne[k]);
      check("distances_out", k, dist_w[k], m_dist[k]);
      if (m_vknown[k] && (!m_busy[k] || m_done[k]))
        check("val", k, val_w[k], m_val[k]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int v);
    resetvalue = W'(v); load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Returns the number of edges from the accepting edge up to the one that raised done.
  task automatic do_start(input int k, output int n);
    enabled = LVLW'(lvl_of(k)); start = 1'b1;
    tick();
    start = 1'b0; n = 1;
    while (done_w[k] == 1'b0 && n < 500) begin
      tick(); n++;
    end
    check("done_timeout", k, (n < 500), 1'b1);
    tick();
  endtask

  task automatic set_marks(input int m1, input int m2);
    marks_in = '0;
    marks_in[0 +: W] = W'(m1);
    marks_in[W +: W] = W'(m2);
  endtask

  initial begin
    int  n;
    bit  saw_done;
    bit  need_load;
    logic [MAXV-1:0] lit;

    repeat (3) tick();
    check("rst_val", 0, val_w[0], 0);
    check("rst_ne", 0, ne_w[0], 3);
    check("rst_ne", 1, ne_w[1], 2);
    rst_n = 1'b1;
    tick();

    // Leaf: candidate 2 clashes on distance 1, candidate 3 accepted.
    set_marks(0, 1); distances = '0; distances[0] = 1'b1; startvalue = 2; limit = 6;
    do_start(0, n);
    check("t1_edges", 0, n, 7);
    check("t1_val", 0, val_w[0], 3);
    check("t1_success", 0, succ_w[0], 1);
    check("t1_ne", 0, ne_w[0], 3);

    // Leaf exhaustion at limit.
    do_load(3); limit = 3;
    do_start(0, n);
    check("t2_edges", 0, n, 2);
    check("t2_val", 0, val_w[0], 0);
    check("t2_ne", 0, ne_w[0], 2);
    check("t2_success", 0, succ_w[0], 0);

    // Inner mark hands off with distance 1 recorded.
    do_load(0); set_marks(0, 0); distances = '0; startvalue = 1; limit = 10;
    do_start(1, n);
    lit = '0; lit[0] = 1'b1;
    check("t3_edges", 1, n, 3);
    check("t3_val", 1, val_w[1], 1);
    check("t3_ne", 1, ne_w[1], 3);
    check("t3_success", 1, succ_w[1], 0);
    check("t3_dist", 1, dist_w[1], lit);

    // Carry out of the W-bit position forces exhaustion.
    do_load(511); limit = 511;
    do_start(0, n);
    check("t4_edges", 0, n, 2);
    check("t4_val", 0, val_w[0], 0);
    check("t4_ne", 0, ne_w[0], 2);

    // Abort in the second CHECK cycle of candidate 5.
    do_load(0); set_marks(0, 1); distances = '0; startvalue = 5; limit = 20;
    enabled = 3; start = 1'b1; saw_done = 0;
    tick(); start = 1'b0; saw_done |= done_w[0];
    tick(); saw_done |= done_w[0];
    tick(); saw_done |= done_w[0];
    abort = 1'b1;
    tick(); abort = 1'b0; saw_done |= done_w[0];
    check("abort_busy", 0, busy_w[0], 0);
    check("abort_nodone", 0, saw_done, 0);
    check("abort_val", 0, val_w[0], 5);
    enabled = 1; start = 1'b1;
    tick(); start = 1'b0;
    check("ignored_busy", 0, busy_w[0], 0);
    check("ignored_busy", 1, busy_w[1], 0);

    // Asynchronous reset in the middle of CHECK.
    do_load(0);
    enabled = 3; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_val", 0, val_w[0], 0);
    check("arst_busy", 0, busy_w[0], 0);
    check("arst_done", 0, done_w[0], 0);
    check("arst_ne", 0, ne_w[0], 3);
    check("arst_ne", 1, ne_w[1], 2);
    check("arst_dist", 1, dist_w[1], 0);
    @(negedge clk); #1 rst_n = 1'b1;
    tick();

    need_load = 0;
    for (int it = 0; it < 80; it++) begin
      if (need_load || ($urandom % 3) == 0) begin
        do_load(($urandom % 2) ? 0 : int'($urandom_range(0, 60)));
        need_load = 0;
      end
      startvalue = W'($urandom_range(1, 30));
      limit      = W'($urandom_range(0, 80));
      for (int j = 0; j < NM; j++) marks_in[j*W +: W] = W'($urandom_range(0, 25));
      distances = '0;
      repeat ($urandom_range(0, 6)) distances[$urandom_range(0, 39)] = 1'b1;
      case ($urandom % 6)
        0, 1:    enabled = 3;
        2, 3:    enabled = 2;
        4:       enabled = 1;
        default: enabled = 4;
      endcase
      start = 1'b1;
      tick(); start = 1'b0;
      if (($urandom % 5) == 0) begin
        repeat ($urandom_range(0, 3)) tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        need_load = 1;
      end
      n = 0;
      while (busy_w != 2'b00 && n < 3000) begin
        tick(); n++;
      end
      check("idle_timeout", it, (n < 3000), 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
